// File: rtl/div_clk_edge_monitor.sv
// div_clk_edge_monitor
//   Receiving end of the divided pixel clock. Synchronises div_clk_in into the
//   clk_100mhz_in domain and turns its edges into single-cycle enable strobes.
//   It also measures the divided-clock period, reports frequency lock and flags
//   loss of the divided clock.
//
// Ports
//   clk_100mhz_in     system clock
//   reset_n_in        asynchronous active-low reset
//   div_clk_in        divided clock under observation (asynchronous)
//   rise_stb_out      one-cycle pulse per detected rising edge
//   fall_stb_out      one-cycle pulse per detected falling edge
//   period_out        last measured period in clk cycles (saturating)
//   period_valid_out  one-cycle pulse when period_out updates
//   locked_out        high while the monitor is frequency locked
//   loss_out          high while the divided clock is considered lost
//   duty_err_out      one-cycle duty-error pulse (DIV_MON_DUTY_CHECK_EN only)
//
// Build option
//   DIV_MON_DUTY_CHECK_EN : adds high-time measurement and duty_err_out; a
//                           duty error makes the period count as a mismatch.
module div_clk_edge_monitor #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned EXPECTED_PERIOD = 4,
  parameter int unsigned PERIOD_TOL      = 0,
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned TIMEOUT         = 16
) (
  input  logic             clk_100mhz_in,
  input  logic             reset_n_in,
  input  logic             div_clk_in,
  output logic             rise_stb_out,
  output logic             fall_stb_out,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid_out,
  output logic             locked_out,
`ifdef DIV_MON_DUTY_CHECK_EN
  output logic             loss_out,
  output logic             duty_err_out
`else
  output logic             loss_out
`endif
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   EXP_C   = CNT_W'(EXPECTED_PERIOD);
  localparam logic [CNT_W-1:0]   TOL_C   = CNT_W'(PERIOD_TOL);
  localparam logic [CNT_W-1:0]   TMO_C   = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] LOCK_C  = MATCH_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   have_prev_q, have_prev_nxt;
  logic [MATCH_W-1:0]     match_q, match_nxt, match_inc_c;
  state_t                 state_q, state_nxt;
  logic [CNT_W-1:0]       period_diff_c;
  logic                   period_ok_c;
  logic                   timeout_c;
  logic                   period_upd_c;

  // Synchroniser chain, previous-sample flop and registered edge strobes
  always_ff @(posedge clk_100mhz_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      rise_stb_out <= 1'b0;
      fall_stb_out <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
      prev_q       <= sync_q[SYNC_STAGES-1];
      rise_stb_out <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_stb_out <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  // Cycles since the last rise strobe; doubles as the loss timer
  always_ff @(posedge clk_100mhz_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cnt_q <= '0;
    end else if (rise_stb_out) begin
      cnt_q <= CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef DIV_MON_DUTY_CHECK_EN
  logic [CNT_W-1:0] hi_cnt_q;
  logic             hi_run_q;
  logic [CNT_W-1:0] half_c;
  logic [CNT_W-1:0] hi_diff_c;
  logic             duty_ok_c;

  // High-time counter: runs from a rise strobe until the following fall strobe
  always_ff @(posedge clk_100mhz_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      hi_cnt_q <= '0;
      hi_run_q <= 1'b0;
    end else if (rise_stb_out) begin
      hi_cnt_q <= CNT_W'(1);
      hi_run_q <= 1'b1;
    end else if (fall_stb_out) begin
      hi_run_q <= 1'b0;
    end else if (hi_run_q && (hi_cnt_q != CNT_MAX)) begin
      hi_cnt_q <= hi_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    half_c    = cnt_q >> 1;
    hi_diff_c = (hi_cnt_q >= half_c) ? (hi_cnt_q - half_c) : (half_c - hi_cnt_q);
    duty_ok_c = (hi_diff_c <= TOL_C);
  end
`endif

  // Period classification; a saturated count can never match
  always_comb begin
    period_diff_c = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
`ifdef DIV_MON_DUTY_CHECK_EN
    period_ok_c   = (cnt_q != CNT_MAX) && (period_diff_c <= TOL_C) && duty_ok_c;
`else
    period_ok_c   = (cnt_q != CNT_MAX) && (period_diff_c <= TOL_C);
`endif
    timeout_c     = (cnt_q >= TMO_C);
    period_upd_c  = rise_stb_out & have_prev_q;
    match_inc_c   = match_q + MATCH_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk_100mhz_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_IDLE;
      match_q     <= '0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      match_q     <= match_nxt;
      have_prev_q <= have_prev_nxt;
    end
  end

  // FSM next state; a rise strobe always beats a simultaneous timeout
  always_comb begin
    state_nxt     = state_q;
    match_nxt     = match_q;
    have_prev_nxt = have_prev_q;
    if (rise_stb_out) have_prev_nxt = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (rise_stb_out) begin
          state_nxt = ST_MEASURE;
          match_nxt = '0;
        end
      end
      ST_MEASURE: begin
        if (rise_stb_out) begin
          if (have_prev_q) begin
            if (!period_ok_c) begin
              match_nxt = '0;
            end else if (match_inc_c >= LOCK_C) begin
              state_nxt = ST_LOCKED;
              match_nxt = '0;
            end else begin
              match_nxt = match_inc_c;
            end
          end
        end else if (timeout_c) begin
          state_nxt     = ST_LOST;
          match_nxt     = '0;
          have_prev_nxt = 1'b0;
        end
      end
      ST_LOCKED: begin
        if (rise_stb_out) begin
          if (have_prev_q && !period_ok_c) begin
            state_nxt = ST_MEASURE;
            match_nxt = '0;
          end
        end else if (timeout_c) begin
          state_nxt     = ST_LOST;
          match_nxt     = '0;
          have_prev_nxt = 1'b0;
        end
      end
      ST_LOST: begin
        if (rise_stb_out) begin
          state_nxt = ST_MEASURE;
          match_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        match_nxt = '0;
      end
    endcase
  end

  // Registered measurement and status outputs
  always_ff @(posedge clk_100mhz_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      period_out       <= '0;
      period_valid_out <= 1'b0;
      locked_out       <= 1'b0;
      loss_out         <= 1'b0;
    end else begin
      if (period_upd_c) period_out <= cnt_q;
      period_valid_out <= period_upd_c;
      locked_out       <= (state_q == ST_LOCKED);
      loss_out         <= (state_q == ST_LOST);
    end
  end

`ifdef DIV_MON_DUTY_CHECK_EN
  // Duty error pulses alongside period_valid_out
  always_ff @(posedge clk_100mhz_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      duty_err_out <= 1'b0;
    end else begin
      duty_err_out <= period_upd_c & ~duty_ok_c;
    end
  end
`endif

endmodule
